// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per cycle, LSB first, result after WIDTH cycles.
// Optional SERIAL_SUB_SAT_EN clamps diff to zero whenever the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             bin, d, bout, last, accept;

  function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] r, input logic br);
    return (SAT_EN && br) ? '0 : r;
  endfunction

  always_comb begin
    d       = sa[0] ^ sb[0] ^ bin;
    bout    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
    res_nxt = {d, res[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start && (state != RUN);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        res <= '0;
        bin <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        res <= res_nxt;
        bin <= bout;
        cnt <= cnt + CW'(1);
        // Outputs are published only when the last bit pair has been processed.
        if (last) begin
          diff   <= sat_diff(res_nxt, bout);
          borrow <= bout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor (WIDTH=8), honouring SERIAL_SUB_SAT_EN.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int NL = 16;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done, borrow;
  logic [W-1:0] a, b, diff;

  logic         ex_start;
  logic [W-1:0] ex_a [NL];
  logic [W-1:0] ex_b [NL];
  logic [W-1:0] ex_diff [NL];
  logic         ex_borrow [NL];
  logic         ex_done [NL];
  logic         ex_busy [NL];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  // Parallel lanes share the sweep so all 65536 pairs fit a short run.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    serial_subtractor #(.WIDTH(W)) u_lane (
      .clk(clk), .rst(rst), .start(ex_start), .a(ex_a[g]), .b(ex_b[g]),
      .busy(ex_busy[g]), .done(ex_done[g]), .diff(ex_diff[g]), .borrow(ex_borrow[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ex_start = 1'b0;
    for (int l = 0; l < NL; l++) begin ex_a[l] = '0; ex_b[l] = '0; end
    tick(); tick();
    n_cmp++;
    if ({busy, done, borrow, diff} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%0b done=%0b borrow=%0b diff=%0d, required all 0", busy, done, borrow, diff);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    int done_early = 0;
    a = 8'd5; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) done_early++;
      tick();
    end
    n_cmp++;
    if (busy_cnt != 8 || done_early != 0) begin
      n_bad++;
      $display("FAIL basic_busy: busy cycles=%0d early done=%0d, required 8 and 0", busy_cnt, done_early);
    end
    n_cmp++;
    if ({done, busy, borrow, diff} !== {1'b1, 1'b0, 1'b0, 8'd2}) begin
      n_bad++;
      $display("FAIL basic_result: done=%0b busy=%0b borrow=%0b diff=%0d, required 1 0 0 2", done, busy, borrow, diff);
    end
    tick();
    n_cmp++;
    if ({done, busy, diff} !== {1'b0, 1'b0, 8'd2}) begin
      n_bad++;
      $display("FAIL basic_hold: done=%0b busy=%0b diff=%0d, required 0 0 2", done, busy, diff);
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] exp_d;
    exp_d = SAT ? 8'd0 : 8'd254;
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    n_cmp++;
    if ({done, borrow, diff} !== {1'b1, 1'b1, exp_d}) begin
      n_bad++;
      $display("FAIL underflow: done=%0b borrow=%0b diff=%0d, required 1 1 %0d", done, borrow, diff, exp_d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d;
    exp_d = SAT ? 8'd0 : 8'd1;
    a = 8'd0; b = 8'd255; start = 1'b1;
    tick();
    a = 8'd255; b = 8'd255;
    repeat (W) tick();
    n_cmp++;
    if ({done, borrow, diff} !== {1'b1, 1'b1, exp_d}) begin
      n_bad++;
      $display("FAIL b2b_first: done=%0b borrow=%0b diff=%0d, required 1 1 %0d", done, borrow, diff, exp_d);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_no_idle: busy=%0b done=%0b, required 1 0", busy, done);
    end
    start = 1'b0;
    repeat (W) tick();
    n_cmp++;
    if ({done, borrow, diff} !== {1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL b2b_second: done=%0b borrow=%0b diff=%0d, required 1 0 0", done, borrow, diff);
    end
    tick();
  endtask

  task automatic test_start_in_run();
    a = 8'd10; b = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'd1; b = 8'd2; end
      else start = 1'b0;
      tick();
    end
    n_cmp++;
    if ({done, borrow, diff} !== {1'b1, 1'b0, 8'd6}) begin
      n_bad++;
      $display("FAIL run_ignore: done=%0b borrow=%0b diff=%0d, required 1 0 6", done, borrow, diff);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL run_ignore_idle: done=%0b busy=%0b, required 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    a = 8'd200; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, borrow, diff} !== 11'd0) begin
      n_bad++;
      $display("FAIL abort: busy=%0b done=%0b borrow=%0b diff=%0d, required all 0", busy, done, borrow, diff);
    end
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: active cycles=%0d, required 0", pulses);
    end
    a = 8'd7; b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_start: busy=%0b, required 1", busy);
    end
    repeat (W) tick();
    n_cmp++;
    if ({done, borrow, diff} !== {1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL post_reset_op: done=%0b borrow=%0b diff=%0d, required 1 0 0", done, borrow, diff);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [15:0]  p;
    logic [W-1:0] ea, eb, ed;
    logic         ebr;
    for (int hi = 0; hi < 65536 / NL; hi++) begin
      for (int l = 0; l < NL; l++) begin
        p = 16'(hi * NL + l);
        ex_a[l] = p[15:8];
        ex_b[l] = p[7:0];
      end
      ex_start = 1'b1;
      tick();
      ex_start = 1'b0;
      repeat (W) tick();
      for (int l = 0; l < NL; l++) begin
        ea  = ex_a[l];
        eb  = ex_b[l];
        ed  = ea - eb;
        ebr = (ea < eb);
        if (SAT && ebr) ed = '0;
        n_cmp++;
        if ({ex_done[l], ex_busy[l], ex_borrow[l], ex_diff[l]} !== {1'b1, 1'b0, ebr, ed}) begin
          n_bad++;
          $display("FAIL exhaustive a=%0d b=%0d: done=%0b busy=%0b borrow=%0b diff=%0d, required 1 0 %0b %0d",
                   ea, eb, ex_done[l], ex_busy[l], ex_borrow[l], ex_diff[l], ebr, ed);
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_start_in_run();
    test_abort();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
